lif_seq: RTL and testbench
==========================

LIF_SEQ -- requirements
Module: lif_seq

Interface
REQ-001 SHALL have parameter V_SIZE, default 8: signed membrane/weight width.
REQ-002 SHALL have parameter N_IN, default 3: presynaptic spike inputs.
REQ-003 SHALL have parameter N_OUT, default 2: neurons time-multiplexed onto one shared LIF datapath.
REQ-004 SHALL have parameter THRESH, default 8: firing threshold, signed V_SIZE.
REQ-005 SHALL have parameter LEAK, default 1: leak arithmetic-shift amount.
REQ-006 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-007 SHALL have port rstn, input, 1: reset, asynchronous, active-low.
REQ-008 SHALL have port start, input, 1: request one timestep evaluation.
REQ-009 SHALL have port in_spikes, input, N_IN: presynaptic spikes, sampled when start is accepted.
REQ-010 SHALL have port cfg_we, input, 1: weight write strobe.
REQ-011 SHALL have port cfg_addr, input, clog2(N_IN*N_OUT): weight index = neuron*N_IN + input.
REQ-012 SHALL have port cfg_wdata, input, V_SIZE: signed weight.
REQ-013 SHALL have port cfg_err, output, 1: one-cycle pulse on a rejected write.
REQ-014 SHALL have port busy, output, 1: high while the timestep is being evaluated.
REQ-015 SHALL have port done, output, 1: one-cycle pulse at timestep completion.
REQ-016 SHALL have port out_spikes, output, N_OUT: spike results, updated only with done and held until the next done.

Function
REQ-017 SHALL use FSM states IDLE, ACC, UPD, DONE.
REQ-018 IDLE: start=1 SHALL latch in_spikes, set neuron index j=0 and input index i=0, then go to ACC.
REQ-019 ACC: each cycle SHALL add weight[j*N_IN+i] to the accumulator if latched spike i=1, then i++; after i=N_IN-1 it SHALL go to UPD.
REQ-020 Accumulator SHALL be at least V_SIZE+clog2(N_IN)+1 bits signed and SHALL be cleared on entry to each neuron's ACC.
REQ-021 UPD (one cycle) SHALL compute v_n = v[j] - (v[j] >>> LEAK) + acc and saturate it to the signed V_SIZE range.
REQ-022 UPD: if v_n >= THRESH, spike bit j SHALL be 1 and v[j] SHALL become 0; otherwise spike bit j SHALL be 0 and v[j] SHALL become v_n.
REQ-023 UPD: if j<N_OUT-1, it SHALL set j++, i=0 and go to ACC; otherwise it SHALL go to DONE.
REQ-024 DONE: it SHALL assert done=1 for one cycle, copy the spike bits to out_spikes in the same cycle, then go to IDLE.
REQ-025 busy SHALL be 1 exactly in ACC and UPD.
REQ-026 Latency: start accepted at edge k SHALL give done=1 during cycle k+1+N_OUT*(N_IN+1), i.e. k+9 at the defaults.
REQ-027 start SHALL be ignored outside IDLE, including in the DONE cycle; no queuing.
REQ-028 A cfg_we write SHALL take effect at the clock edge only when the FSM is in IDLE and cfg_addr < N_IN*N_OUT.
REQ-029 Any other write SHALL be dropped, with cfg_err=1 in the next cycle.
REQ-030 If cfg_we and start are high in the same IDLE cycle, the write SHALL complete and the evaluation SHALL use the new weight.
REQ-031 Membrane state v[0..N_OUT-1] SHALL persist across timesteps and SHALL change only in UPD or on reset.

Reset
REQ-032 rstn=0 SHALL, asynchronously: FSM=IDLE; i=j=0; accumulator=0; all v=0; all weights=0; out_spikes=0; busy=done=cfg_err=0.
REQ-033 Reset mid-evaluation SHALL abort it with no done pulse; the first start after rstn=1 SHALL evaluate normally.

Verification (defaults)
REQ-034 Weights n0={3,3,3}, in_spikes=111, start at edge 0 -> busy cycles 1-8, done in cycle 9, out_spikes[0]=1, v[0]=0.
REQ-035 Weights n1={0,2,2}, in_spikes=011, four timesteps -> v[1]=4,6,7 then fire; out_spikes[1]=0,0,0,1; v[1]=0.
REQ-036 Weights n0={-128,-128,-128}, spikes 111 -> v[0] saturates to -128; next step with spikes 000 -> v[0]=-64, no spike.
REQ-037 start pulsed in cycles 3 and 9 of a busy run -> exactly one done; cfg_we during busy -> weight unchanged, cfg_err=1 next cycle; cfg_addr=6 while IDLE -> cfg_err=1.
REQ-038 rstn=0 in cycle 5 of an evaluation -> outputs zero immediately, no done; rerun of REQ-034 stimulus gives out_spikes=00, because the weights were cleared.

Source files
------------

// File: rtl/lif_seq.sv
// lif_seq: N_OUT leaky integrate-and-fire neurons sharing one datapath.
// Each timestep walks neuron j = 0..N_OUT-1. For each neuron it spends N_IN
// cycles accumulating the weights of the latched spiking inputs. It then
// spends one cycle applying leak, saturation and the threshold test. A
// single DONE cycle publishes the spike vector.
//
// Ports
//   clk, rstn   : rising-edge clock, asynchronous active-low reset
//   start       : request a timestep (honoured only in IDLE)
//   in_spikes   : presynaptic spikes, latched when start is accepted
//   cfg_we/addr/wdata : weight write, index = neuron*N_IN + input
//   cfg_err     : one-cycle pulse after a rejected write
//   busy        : high while accumulating/updating
//   done        : one-cycle pulse, coincident with new out_spikes
//   out_spikes  : spike result, held between done pulses
module lif_seq #(
    parameter int V_SIZE = 8,
    parameter int N_IN   = 3,
    parameter int N_OUT  = 2,
    parameter int THRESH = 8,
    parameter int LEAK   = 1,
    localparam int NW    = N_IN * N_OUT,
    localparam int AW    = (NW > 1) ? $clog2(NW) : 1
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     start,
    input  logic [N_IN-1:0]          in_spikes,
    input  logic                     cfg_we,
    input  logic [AW-1:0]            cfg_addr,
    input  logic signed [V_SIZE-1:0] cfg_wdata,
    output logic                     cfg_err,
    output logic                     busy,
    output logic                     done,
    output logic [N_OUT-1:0]         out_spikes
);

    localparam int IW    = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int JW    = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    // Worst-case sum of N_IN weights plus a sign bit of headroom.
    localparam int ACC_W = V_SIZE + $clog2(N_IN) + 1;
    // Update arithmetic width: v - leak + acc cannot overflow here.
    localparam int DW    = ACC_W + 2;

    localparam logic signed [DW-1:0]     VMAX_D = DW'((1 << (V_SIZE-1)) - 1);
    localparam logic signed [DW-1:0]     VMIN_D = DW'(-(1 << (V_SIZE-1)));
    localparam logic signed [V_SIZE-1:0] VMAX_V = V_SIZE'((1 << (V_SIZE-1)) - 1);
    localparam logic signed [V_SIZE-1:0] VMIN_V = V_SIZE'(-(1 << (V_SIZE-1)));
    localparam logic signed [V_SIZE-1:0] THR_V  = V_SIZE'(THRESH);
    localparam logic [IW-1:0]            I_LAST = IW'(N_IN - 1);
    localparam logic [JW-1:0]            J_LAST = JW'(N_OUT - 1);
    localparam logic [AW:0]              NW_L   = (AW+1)'(NW);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ACC  = 2'd1;
    localparam logic [1:0] UPD  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]                     state;
    logic [IW-1:0]                  i;
    logic [JW-1:0]                  j;
    logic [N_IN-1:0]                spk_in;
    logic signed [ACC_W-1:0]        acc;
    logic [N_OUT-1:0][V_SIZE-1:0]   v;
    logic [NW-1:0][V_SIZE-1:0]      w;
    logic [N_OUT-1:0]               spk;

    logic [AW-1:0]                  widx;
    logic signed [V_SIZE-1:0]       w_cur;
    logic signed [V_SIZE-1:0]       v_cur;
    logic signed [DW-1:0]           v_ext;
    logic signed [DW-1:0]           acc_ext;
    logic signed [DW-1:0]           v_n;
    logic signed [V_SIZE-1:0]       v_sat;
    logic                           fire;
    logic [N_OUT-1:0]               spk_nx;
    logic                           wr_ok;

    assign widx    = AW'(int'(j) * N_IN + int'(i));
    assign w_cur   = w[widx];
    assign v_cur   = v[j];
    assign v_ext   = DW'(v_cur);
    assign acc_ext = DW'(acc);
    assign v_n     = v_ext - (v_ext >>> LEAK) + acc_ext;

    always_comb begin
        v_sat = v_n[V_SIZE-1:0];
        if (v_n > VMAX_D)
            v_sat = VMAX_V;
        else if (v_n < VMIN_D)
            v_sat = VMIN_V;
    end

    assign fire = (v_sat >= THR_V);

    always_comb begin
        spk_nx    = spk;
        spk_nx[j] = fire;
    end

    // Writes land only while idle so an evaluation never sees a weight
    // change mid-flight; a write alongside start still lands first.
    assign wr_ok = cfg_we && (state == IDLE) && ({1'b0, cfg_addr} < NW_L);

    assign busy = (state == ACC) || (state == UPD);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            i          <= '0;
            j          <= '0;
            spk_in     <= '0;
            acc        <= '0;
            v          <= '0;
            w          <= '0;
            spk        <= '0;
            out_spikes <= '0;
            cfg_err    <= 1'b0;
        end else begin
            cfg_err <= cfg_we && !wr_ok;
            if (wr_ok)
                w[cfg_addr] <= cfg_wdata;

            case (state)
                IDLE: begin
                    if (start) begin
                        spk_in <= in_spikes;
                        i      <= '0;
                        j      <= '0;
                        acc    <= '0;
                        state  <= ACC;
                    end
                end
                ACC: begin
                    if (spk_in[i])
                        acc <= acc + ACC_W'(w_cur);
                    if (i == I_LAST)
                        state <= UPD;
                    else
                        i <= i + 1'b1;
                end
                UPD: begin
                    v[j] <= fire ? '0 : v_sat;
                    spk  <= spk_nx;
                    if (j == J_LAST) begin
                        out_spikes <= spk_nx;
                        state      <= DONE;
                    end else begin
                        j     <= j + 1'b1;
                        i     <= '0;
                        acc   <= '0;
                        state <= ACC;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lif_seq.sv
// Directed bench for lif_seq at default parameters (V_SIZE=8, N_IN=3,
// N_OUT=2, THRESH=8, LEAK=1). Expected values are hand-computed below.
module tb_lif_seq;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       start = 1'b0;
    logic [2:0] in_spikes = '0;
    logic       cfg_we = 1'b0;
    logic [2:0] cfg_addr = '0;
    logic [7:0] cfg_wdata = '0;
    logic       cfg_err;
    logic       busy;
    logic       done;
    logic [1:0] out_spikes;

    int total = 0;
    int bad = 0;
    int done_at, busy_n, done_n, dn;
    logic [1:0] os;

    lif_seq dut (
        .clk(clk), .rstn(rstn), .start(start), .in_spikes(in_spikes),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .cfg_err(cfg_err), .busy(busy), .done(done), .out_spikes(out_spikes)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        tick();
        cfg_we = 1'b0;
    endtask

    // One timestep with a bounded watch window; cycle n is the n-th cycle
    // after the accepting edge.
    task automatic run_ts(input logic [2:0] sp);
        start = 1'b1; in_spikes = sp;
        tick();
        start = 1'b0; cfg_we = 1'b0;
        done_at = 0; busy_n = 0; done_n = 0; os = 'x;
        for (int n = 1; n <= 12; n++) begin
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (done_at == 0) begin
                    done_at = n;
                    os = out_spikes;
                end
            end
            tick();
        end
    endtask

    initial begin
        // reset state
        #2;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, cfg_err}, 32'd0);
        chk("rst_out", {30'd0, out_spikes}, 32'd0);
        tick(); tick();
        rstn = 1'b1;
        tick();

        // n0 = {3,3,3}, spikes 111: acc 9 -> fires, v0 = 0; n1 idle
        wr(3'd0, 8'd3); wr(3'd1, 8'd3); wr(3'd2, 8'd3);
        chk("wr_ok_err", {31'd0, cfg_err}, 32'd0);
        run_ts(3'b111);
        chk("t1_lat", done_at, 32'd9);
        chk("t1_busy", busy_n, 32'd8);
        chk("t1_ndone", done_n, 32'd1);
        chk("t1_out", {30'd0, os}, 32'd1);
        chk("t1_v0", {24'd0, dut.v[0]}, 32'd0);

        // n1 w0=2,w1=2,w2=0, spikes 011: acc 4 -> v1 4,6,7,fire.
        // n0 acc 6: v0 6, fire, 6, fire.
        wr(3'd3, 8'd2); wr(3'd4, 8'd2); wr(3'd5, 8'd0);
        run_ts(3'b011);
        chk("t2a_out", {30'd0, os}, 32'd0);
        chk("t2a_v1", {24'd0, dut.v[1]}, 32'd4);
        run_ts(3'b011);
        chk("t2b_out", {30'd0, os}, 32'd1);
        chk("t2b_v1", {24'd0, dut.v[1]}, 32'd6);
        run_ts(3'b011);
        chk("t2c_out", {30'd0, os}, 32'd0);
        chk("t2c_v1", {24'd0, dut.v[1]}, 32'd7);
        run_ts(3'b011);
        chk("t2d_out", {30'd0, os}, 32'd3);
        chk("t2d_v1", {24'd0, dut.v[1]}, 32'd0);

        // n0 = -128 x3, spikes 111: -384 saturates to -128; then leak to -64
        wr(3'd0, 8'h80); wr(3'd1, 8'h80); wr(3'd2, 8'h80);
        run_ts(3'b111);
        chk("t3a_v0", {24'd0, dut.v[0]}, 32'h80);
        chk("t3a_out", {30'd0, os}, 32'd0);
        run_ts(3'b000);
        chk("t3b_v0", {24'd0, dut.v[0]}, 32'hC0);
        chk("t3b_out", {30'd0, os}, 32'd0);

        // start re-pulsed in cycles 3 and 9, write attempted in cycle 5
        start = 1'b1; in_spikes = 3'b000;
        tick();
        dn = 0;
        for (int c = 1; c <= 20; c++) begin
            if (done) dn++;
            if (c == 6) chk("t4_busy_err", {31'd0, cfg_err}, 32'd1);
            start = (c == 3) || (c == 9);
            cfg_we = (c == 5); cfg_addr = 3'd0; cfg_wdata = 8'd5;
            tick();
        end
        start = 1'b0; cfg_we = 1'b0;
        chk("t4_ndone", dn, 32'd1);
        chk("t4_w0_kept", {24'd0, dut.w[0]}, 32'h80);

        // out-of-range address while idle
        wr(3'd6, 8'd1);
        chk("t4_addr_err", {31'd0, cfg_err}, 32'd1);
        tick();
        chk("t4_err_pulse", {31'd0, cfg_err}, 32'd0);

        // write with start in the same cycle: v0=-32, w2=127 -> 111, fires.
        // With the stale w2 (-128) it would saturate low and stay quiet.
        wr(3'd0, 8'd0); wr(3'd1, 8'd0);
        cfg_we = 1'b1; cfg_addr = 3'd2; cfg_wdata = 8'd127;
        run_ts(3'b111);
        chk("t5_same_cyc", {30'd0, os}, 32'd1);

        // reset in cycle 5 of an evaluation
        start = 1'b1; in_spikes = 3'b111;
        tick();
        start = 1'b0;
        repeat (4) tick();
        rstn = 1'b0;
        #1;
        chk("t6_busy", {31'd0, busy}, 32'd0);
        chk("t6_done", {31'd0, done}, 32'd0);
        chk("t6_out", {30'd0, out_spikes}, 32'd0);
        tick();
        rstn = 1'b1;
        dn = 0;
        for (int c = 0; c < 12; c++) begin
            if (done) dn++;
            tick();
        end
        chk("t6_nodone", dn, 32'd0);
        run_ts(3'b111);
        chk("t6_lat", done_at, 32'd9);
        chk("t6_out_after", {30'd0, os}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
